lfsr_stream_gen: RTL and testbench
==================================

// Module: lfsr_stream_gen
// PURPOSE
//  Parametrised Fibonacci LFSR keystream generator; next generation of the fixed
//  5/7/9-bit LFSR cells. Width, tap polynomial and bits-per-transfer are
//  generic. Adds seed loading, a valid/ready output handshake, zero-state
//  lockup detection and a transfer counter. Feeds the combiner/XOR stage.
// PARAMETERS
//  WIDTH        9        LFSR length in bits; range 3..32.
//  TAPS         9'h110   feedback mask; fb = ^(s & TAPS); bit WIDTH-1 must be set.
//  OUT_W        1        keystream bits per transfer (LFSR steps per transfer); range 1..WIDTH.
//  DEFAULT_SEED 9'h001   state after reset; must be non-zero.
//  CNT_W        16       width of the transfer counter.
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous reset, active low
//  load       in   1      load seed this cycle (highest priority)
//  seed       in   WIDTH  seed value, sampled when load=1
//  enable     in   1      run request; generator produces chunks while high
//  out_ready  in   1      consumer accepts out_bits
//  out_valid  out  1      out_bits holds a valid chunk
//  out_bits   out  OUT_W  keystream chunk; bit 0 is the oldest bit
//  state      out  WIDTH  current LFSR register (debug)
//  lockup     out  1      LFSR register is all-zero
//  xfer_cnt   out  CNT_W  accepted transfers since reset/load; saturates
// BEHAVIOUR
//  - Single step: bit = s[0]; fb = ^(s & TAPS); s <= {s[WIDTH-2:0], fb}.
//  - Chunk: OUT_W steps unrolled combinationally in one cycle;
//    out_bits[k] = s[0] after k steps; s advances OUT_W steps per chunk.
//  - Reset (async): s=DEFAULT_SEED, out_valid=0, out_bits=0, xfer_cnt=0,
//    lockup=0, FSM=IDLE.
//  - FSM states: IDLE, RUN, LOCK.
//    IDLE->RUN when enable=1; RUN->IDLE when enable=0 and out_valid=0
//    (or the pending chunk is being accepted); any->LOCK when s becomes 0;
//    LOCK->IDLE only on load with non-zero seed.
//  - Produce: in RUN, when !out_valid || out_ready, register the chunk from the
//    current s and set out_valid=1. Latency: out_valid rises one cycle after
//    enable is first sampled high in IDLE.
//  - Handshake: a transfer occurs when out_valid && out_ready. While
//    out_valid=1 and out_ready=0, out_bits and s are held stable. Dropping
//    enable never withdraws a pending chunk; when that chunk is accepted with
//    enable=0, out_valid falls and no further chunk is produced.
//  - Back-to-back: with out_ready=1 and enable=1, one chunk per cycle.
//  - load: s<=seed, out_valid<=0 (pending chunk discarded), xfer_cnt<=0,
//    FSM->IDLE (or LOCK if seed=0). Overrides a same-cycle transfer, which is
//    not counted. Production resumes the following cycle if enable=1.
//  - xfer_cnt increments on each transfer; holds at 2^CNT_W-1.
//  - lockup = (s == 0), registered with s. In LOCK: out_valid=0, enable ignored.
//  - Parameter checks: elaboration error if TAPS[WIDTH-1]=0, DEFAULT_SEED=0 or
//    OUT_W outside 1..WIDTH.
// CONFIGURATION
//  LFSR_ZERO_RECOVER_EN defined: a zero seed on load (or any zero state) is
//    replaced by DEFAULT_SEED in the same update; lockup pulses high for exactly
//    one cycle; the FSM never enters LOCK.
//  Not defined: zero state enters LOCK as above; lockup stays high until a
//    non-zero load.
// TESTING  (WIDTH=5, TAPS=5'h14, DEFAULT_SEED=5'h01 unless stated)
//  1 Reset, enable=1, out_ready=1, OUT_W=1 -> out_bits stream 1,0,0,1,0,1,...;
//    state=5'h01 again after exactly 31 transfers; xfer_cnt=31.
//  2 OUT_W=4, same setup -> first chunk out_bits=4'b1001, state=5'b10010;
//    out_valid first high one cycle after enable.
//  3 Backpressure: out_ready=0 for 5 cycles mid-stream -> out_bits/state frozen,
//    out_valid=1 held; on release the stream continues with no bit lost or
//    repeated.
//  4 load seed=5'h01 while out_valid=1,out_ready=1 -> chunk not counted,
//    xfer_cnt=0, next chunk restarts at 1,0,0,1.
//  5 load seed=0 -> without macro: lockup=1, out_valid=0 until load seed=5'h03;
//    with LFSR_ZERO_RECOVER_EN: state=5'h01, lockup high for one cycle only.
//  6 Assert reset_n low mid-stream, off clock edge -> outputs take reset values
//    immediately; CNT_W=4 run of 20 transfers -> xfer_cnt saturates at 15.

Source files
------------

// File: rtl/lfsr_stream_gen.sv
// Fibonacci LFSR keystream generator: seed load, valid/ready chunk output, lockup flag, transfer counter.
// Build option LFSR_ZERO_RECOVER_EN: an all-zero state is replaced by DEFAULT_SEED instead of locking.
//
// state | meaning
// IDLE  | no chunk pending, waiting for enable
// RUN   | producing chunks or holding a pending chunk
// LOCK  | register is all-zero, waiting for a non-zero seed load
module lfsr_stream_gen #(
    parameter int               WIDTH        = 9,
    parameter logic [WIDTH-1:0] TAPS         = 9'h110,
    parameter int               OUT_W        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 9'h001,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_bits,
    output logic [WIDTH-1:0] state,
    output logic             lockup,
    output logic [CNT_W-1:0] xfer_cnt
);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_stream_gen: WIDTH must be in 3..32");
    end
    if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
        $error("lfsr_stream_gen: TAPS[WIDTH-1] must be set");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
        $error("lfsr_stream_gen: DEFAULT_SEED must be non-zero");
    end
    if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_out_w
        $error("lfsr_stream_gen: OUT_W must be in 1..WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOCK = 2'd2
    } fsm_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_q, lock_d;
    logic [WIDTH-1:0] walk;
    logic [OUT_W-1:0] chunk;
    logic             xfer;
`ifdef LFSR_ZERO_RECOVER_EN
    logic             zero_hit;
`endif

    // OUT_W single steps unrolled; walk ends as the register value after the chunk
    always_comb begin
        walk  = s_q;
        chunk = '0;
        for (int k = 0; k < OUT_W; k++) begin
            chunk[k] = walk[0];
            walk     = {walk[WIDTH-2:0], ^(walk & TAPS)};
        end
    end

    assign xfer = valid_q && out_ready;

    always_comb begin
        fsm_d   = fsm_q;
        s_d     = s_q;
        valid_d = valid_q;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
`ifdef LFSR_ZERO_RECOVER_EN
        zero_hit = 1'b0;
`endif
        if (load) begin
            fsm_d   = ST_IDLE;
            s_d     = seed;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (fsm_q)
                ST_IDLE: begin
                    if (enable) fsm_d = ST_RUN;
                end
                ST_RUN: begin
                    if (xfer && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (!valid_q || out_ready) begin
                        if (enable) begin
                            bits_d  = chunk;
                            s_d     = walk;
                            valid_d = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            fsm_d   = ST_IDLE;
                        end
                    end
                end
                ST_LOCK: begin
                    valid_d = 1'b0;
                end
                default: begin
                    fsm_d   = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        // an all-zero register can only arise from a zero seed load
        if (s_d == '0) begin
`ifdef LFSR_ZERO_RECOVER_EN
            s_d      = DEFAULT_SEED;
            zero_hit = 1'b1;
`else
            fsm_d    = ST_LOCK;
            valid_d  = 1'b0;
`endif
        end
    end

`ifdef LFSR_ZERO_RECOVER_EN
    assign lock_d = zero_hit;
`else
    assign lock_d = (s_d == '0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= ST_IDLE;
            s_q     <= DEFAULT_SEED;
            valid_q <= 1'b0;
            bits_q  <= '0;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
        end
    end

    assign out_valid = valid_q;
    assign out_bits  = bits_q;
    assign state     = s_q;
    assign lockup    = lock_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: two 5-bit instances (1-bit and 4-bit chunks) against a keystream scoreboard.
module tb_lfsr_stream_gen;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [4:0]  seed;
    logic        enable;
    logic        out_ready;

    logic        v1;
    logic [0:0]  b1;
    logic [4:0]  st1;
    logic        lk1;
    logic [15:0] c1;
    logic        v4;
    logic [3:0]  b4;
    logic [4:0]  st4;
    logic        lk4;
    logic [3:0]  c4;

    int total = 0;
    int bad   = 0;

    lfsr_stream_gen #(.WIDTH(5), .TAPS(5'h14), .OUT_W(1), .DEFAULT_SEED(5'h01), .CNT_W(16)) u1 (
        .clk(clk), .reset_n(reset_n), .load(load), .seed(seed), .enable(enable),
        .out_ready(out_ready), .out_valid(v1), .out_bits(b1), .state(st1),
        .lockup(lk1), .xfer_cnt(c1)
    );

    lfsr_stream_gen #(.WIDTH(5), .TAPS(5'h14), .OUT_W(4), .DEFAULT_SEED(5'h01), .CNT_W(4)) u4 (
        .clk(clk), .reset_n(reset_n), .load(load), .seed(seed), .enable(enable),
        .out_ready(out_ready), .out_valid(v4), .out_bits(b4), .state(st4),
        .lockup(lk4), .xfer_cnt(c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step(input int s);
        int fb;
        fb = $countones(s & 32'h14) & 1;
        return ((s << 1) | fb) & 32'h1f;
    endfunction

    function automatic int adv(input int s, input int n);
        int r;
        r = s;
        for (int k = 0; k < n; k++) r = step(r);
        return r;
    endfunction

    function automatic int chunk_of(input int s, input int n);
        int r;
        int t;
        r = 0;
        t = s;
        for (int k = 0; k < n; k++) begin
            r = r | ((t & 1) << k);
            t = step(t);
        end
        return r;
    endfunction

    // scoreboard: cur = register value from which the next accepted chunk is generated
    int       cur[2];
    int       acc[2];
    bit       locked[2];
    bit       pulse[2];
    bit       pv[2];
    logic [3:0] pb[2];
    bit       p_en, p_rdy, p_load;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cur[i] = 1; acc[i] = 0; locked[i] = 0; pulse[i] = 0; pv[i] = 0; pb[i] = 0;
        end
        p_en = 0; p_rdy = 0; p_load = 0;
    endtask

    task automatic mon(input int i, input logic v, input logic [3:0] bits, input logic [4:0] st,
                       input logic lk, input logic [15:0] cnt);
        int n;
        int mx;
        int exp_st;
        n  = (i == 0) ? 1 : 4;
        mx = (i == 0) ? 65535 : 15;
        if (locked[i]) begin
            chk("lock_valid", v, 0);
            chk("lock_state", st, 0);
            chk("lock_flag", lk, 1);
        end else begin
            exp_st = v ? adv(cur[i], n) : cur[i];
            chk("state", st, exp_st);
            chk("lockup", lk, pulse[i]);
            if (p_load) chk("valid_after_load", v, 0);
            else if (pv[i] && !p_rdy) begin
                chk("hold_valid", v, 1);
                chk("hold_bits", bits, pb[i]);
            end
            else if (pv[i] && p_rdy) chk("b2b_valid", v, p_en);
            else if (!p_en) chk("no_start", v, 0);
        end
        chk("xfer_cnt", cnt, (acc[i] > mx) ? mx : acc[i]);

        if (load) begin
            acc[i] = 0;
            if (seed == 0) begin
`ifdef LFSR_ZERO_RECOVER_EN
                cur[i] = 1; locked[i] = 0; pulse[i] = 1;
`else
                cur[i] = 0; locked[i] = 1; pulse[i] = 0;
`endif
            end else begin
                cur[i] = seed; locked[i] = 0; pulse[i] = 0;
            end
        end else begin
            pulse[i] = 0;
            if (!locked[i] && v && out_ready) begin
                chk("bits", bits, chunk_of(cur[i], n));
                cur[i] = adv(cur[i], n);
                acc[i]++;
            end
        end
        pv[i] = v;
        pb[i] = bits;
    endtask

    always @(negedge clk) begin
        if (!reset_n) model_reset();
        else begin
            mon(0, v1, {3'b000, b1}, st1, lk1, c1);
            mon(1, v4, b4, st4, lk4, {12'h000, c4});
            p_en = enable; p_rdy = out_ready; p_load = load;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        reset_n = 1'b0; load = 1'b0; seed = 5'h00; enable = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("rst_valid", v4, 0);
        chk("rst_bits", b4, 0);
        chk("rst_state", st4, 5'h01);
        chk("rst_lockup", lk4, 0);
        chk("rst_cnt", c1, 0);
        #2 reset_n = 1'b1;
        cyc(3);

        // first-chunk latency and contents
        enable = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("lat_not_yet", v4, 0);
        @(posedge clk); @(negedge clk);
        chk("lat_valid", v4, 1);
        chk("first_chunk4", b4, 4'b1001);
        chk("first_state4", st4, 5'b10010);
        chk("first_bit1", b1, 1);
        chk("first_state1", st1, 5'h02);

        // full period of the 1-bit stream
        repeat (31) @(posedge clk);
        @(negedge clk);
        chk("period_cnt", c1, 31);
        chk("period_state", st1, 5'h02);
        chk("period_bit", b1, 1);
        chk("sat_cnt4", c4, 15);

        // backpressure
        cyc(1);
        out_ready = 1'b0;
        cyc(5);
        out_ready = 1'b1;
        cyc(3);

        // load during an accepted transfer
        chk("pre_load_valid", v4, 1);
        load = 1'b1; seed = 5'h01;
        cyc(1);
        load = 1'b0;
        @(negedge clk);
        chk("load_cnt1", c1, 0);
        chk("load_cnt4", c4, 0);
        chk("load_valid", v4, 0);
        for (int k = 0; k < 6; k++) begin
            if (v4) break;
            @(negedge clk);
        end
        chk("restart_seen", v4, 1);
        chk("restart_bits", b4, 4'b1001);

        // zero seed
        cyc(1);
        load = 1'b1; seed = 5'h00;
        cyc(1);
        load = 1'b0;
        @(negedge clk);
`ifdef LFSR_ZERO_RECOVER_EN
        chk("zero_state", st4, 5'h01);
        chk("zero_pulse", lk4, 1);
        @(negedge clk);
        chk("zero_pulse_end", lk4, 0);
`else
        chk("zero_lock", lk4, 1);
        chk("zero_valid", v4, 0);
        repeat (4) @(negedge clk);
        chk("zero_still_lock", lk4, 1);
        chk("zero_still_idle", v1, 0);
        cyc(1);
        load = 1'b1; seed = 5'h03;
        cyc(1);
        load = 1'b0;
        @(negedge clk);
        chk("unlock_flag", lk4, 0);
        chk("unlock_state", st4, 5'h03);
`endif

        // randomized traffic
        cyc(1);
        for (int k = 0; k < 800; k++) begin
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            load      = ($urandom_range(0, 49) == 0);
            seed      = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom_range(1, 31));
            cyc(1);
        end
        load = 1'b1; seed = 5'h05; enable = 1'b1; out_ready = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(10);

        // asynchronous reset mid-stream, then counter saturation
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", v4, 0);
        chk("arst_bits", b4, 0);
        chk("arst_state", st1, 5'h01);
        chk("arst_cnt", c1, 0);
        chk("arst_lockup", lk4, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("sat_hold4", c4, 15);
        chk("nosat_cnt1", c1, 23);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
